multdiv_ctrl: RTL

Sequences the shared multi-cycle multiply/divide unit for the 5-stage pipeline.
- Detects a mul/div ALU instruction sitting in the XM stage and pulses the unit's start control.
- Holds the pipeline stalled until the unit reports ready, or until a watchdog expires.
- Delivers a single-cycle writeback request into the XM/MW result path. On a unit exception, the write is redirected to $rstatus.

---
 rtl/multdiv_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - sequencer for the shared multi-cycle multiply/divide unit
//
// Watches the XM stage for mul/div ALU instructions. It starts the shared
// unit, stalls the pipeline while the unit works, and hands one writeback
// request to the XM/MW result path. When the unit reports an exception, or
// when the watchdog expires, the write goes to $rstatus (r30) and carries an
// error code.
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   synchronous, active-high reset
//   xm_is_alu     in   XM instruction has the ALU R-type opcode
//   xm_aluop      in   XM ALU op field (00110 mul, 00111 div)
//   xm_rd         in   XM destination register
//   md_ready      in   unit result valid (level or pulse)
//   md_exception  in   unit exception, qualified by md_ready
//   md_result     in   unit result, qualified by md_ready
//   ctrl_mult     out  one-cycle multiply start pulse
//   ctrl_div      out  one-cycle divide start pulse
//   stall         out  freezes PC, FD, DX and XM latches (combinational)
//   busy          out  controller not idle
//   wb_valid      out  one-cycle writeback request
//   wb_rd         out  writeback destination
//   wb_data       out  writeback data
//   timeout       out  sticky watchdog flag, cleared only by reset

module multdiv_ctrl #(
    parameter int CNT_W   = 6,
    parameter int TIMEOUT = 40,
    parameter int MUL_ERR = 4,
    parameter int DIV_ERR = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        xm_is_alu,
    input  logic [4:0]  xm_aluop,
    input  logic [4:0]  xm_rd,
    input  logic        md_ready,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        stall,
    output logic        busy,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        timeout
);

    localparam logic [4:0]       OP_MUL    = 5'b00110;
    localparam logic [4:0]       OP_DIV    = 5'b00111;
    localparam logic [4:0]       RSTATUS   = 5'd30;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0]      MUL_CODE  = 32'(MUL_ERR);
    localparam logic [31:0]      DIV_CODE  = 32'(DIV_ERR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              is_div_q;
    logic [4:0]        rd_q;
    logic [31:0]       res_q;
    logic              exc_q;
    logic              md_issue;

    assign md_issue = xm_is_alu & ((xm_aluop == OP_MUL) | (xm_aluop == OP_DIV));

    // The detect term lets the stall begin in the same cycle the instruction
    // reaches XM. DONE is deliberately left out, so the finished mul/div
    // moves on at the DONE edge and IDLE never sees it a second time.
    assign stall = !reset & (((state == S_IDLE) & md_issue) |
                             (state == S_START) | (state == S_WAIT));

    assign busy = (state != S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            is_div_q  <= 1'b0;
            rd_q      <= '0;
            res_q     <= '0;
            exc_q     <= 1'b0;
            ctrl_mult <= 1'b0;
            ctrl_div  <= 1'b0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            timeout   <= 1'b0;
        end else begin
            // Pulse outputs default low, so each one lasts a single cycle
            ctrl_mult <= 1'b0;
            ctrl_div  <= 1'b0;
            wb_valid  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (md_issue) begin
                        state     <= S_START;
                        is_div_q  <= xm_aluop[0];
                        rd_q      <= xm_rd;
                        // Registered here so the start pulse lines up with START
                        ctrl_mult <= !xm_aluop[0];
                        ctrl_div  <= xm_aluop[0];
                    end
                end

                S_START: begin
                    cnt   <= '0;
                    exc_q <= 1'b0;
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    // A result that arrives on the limit cycle still completes normally
                    if (md_ready) begin
                        res_q <= md_result;
                        exc_q <= md_exception;
                        state <= S_DONE;
                    end else if (cnt == CNT_LIMIT) begin
                        exc_q   <= 1'b1;
                        timeout <= 1'b1;
                        state   <= S_DONE;
                    end
                end

                S_DONE: begin
                    wb_valid <= 1'b1;
                    if (exc_q) begin
                        wb_rd   <= RSTATUS;
                        wb_data <= is_div_q ? DIV_CODE : MUL_CODE;
                    end else begin
                        // rd 0 is still requested; the regfile drops r0 writes
                        wb_rd   <= rd_q;
                        wb_data <= res_q;
                    end
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
